// File: rtl/mac_result_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_drain_if
// Purpose  : Word-stream interface from the MAC result drain toward the
//            writeback/output buffer.
// Signals  : out_data  - current output word (signed, ACC_W bits)
//            out_idx   - lane index of out_data (0..3)
//            out_last  - high on the lane-3 word of a frame
//            out_valid - out_data is valid
//            out_ready - consumer accepts the word when out_valid&&out_ready
// Modports : master (drain side), slave (consumer side)
// Revision : 1.0 - initial release
// ============================================================================
interface mac_result_drain_if #(
    parameter int ACC_W = 16
);
    logic signed [ACC_W-1:0] out_data;
    logic        [1:0]       out_idx;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output out_data,
        output out_idx,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/mac_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_drain
// Purpose  : Collects the four accumulator results of the 2x2 MAC array into
//            a frame, buffers up to DEPTH frames and streams them out one
//            word at a time (lane 0..3) on a valid/ready interface.
// Ports    : clk, rst_n (async, active-low)
//            acc_in_0..3   - signed results from MAC 0..3
//            valid_in      - per-lane result strobe
//            clr_err       - synchronous clear of overwrite_err / drop_cnt
//            out_if        - word stream (mac_result_drain_if.master)
//            frame_cnt     - frames currently held in the FIFO
//            overwrite_err - sticky: lane re-strobed before frame completed
//            drop_cnt      - saturating count of frames dropped when full
// Options  : RESULT_RELU_EN - when defined, negative words are output as 0
//            (the FIFO always stores raw values).
// Revision : 1.0 - initial release
// ============================================================================
module mac_result_drain #(
    parameter int ACC_W  = 16,
    parameter int N_MACS = 4,
    parameter int DEPTH  = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic signed [ACC_W-1:0]    acc_in_0,
    input  wire logic signed [ACC_W-1:0]    acc_in_1,
    input  wire logic signed [ACC_W-1:0]    acc_in_2,
    input  wire logic signed [ACC_W-1:0]    acc_in_3,
    input  wire logic [N_MACS-1:0]          valid_in,
    input  wire logic                       clr_err,
    mac_result_drain_if.master              out_if,
    output logic [$clog2(DEPTH):0]          frame_cnt,
    output logic                            overwrite_err,
    output logic [7:0]                      drop_cnt
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Capture stage
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]   w_acc   [N_MACS];
    logic [ACC_W-1:0]   w_frame [N_MACS];
    logic [ACC_W-1:0]   r_lane  [N_MACS];
    logic [N_MACS-1:0]  r_flag;

    assign w_acc[0] = acc_in_0;
    assign w_acc[1] = acc_in_1;
    assign w_acc[2] = acc_in_2;
    assign w_acc[3] = acc_in_3;

    // A lane strobing in the completing cycle contributes its live input,
    // so the frame is pushed without waiting an extra cycle.
    for (genvar gi = 0; gi < N_MACS; gi++) begin : g_lane
        assign w_frame[gi] = valid_in[gi] ? w_acc[gi] : r_lane[gi];
    end

    logic w_complete;
    logic w_ovw;
    assign w_complete = &(r_flag | valid_in);
    assign w_ovw      = |(r_flag & valid_in);

    // ------------------------------------------------------------------
    // Frame FIFO and output sequencing
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]   r_mem [DEPTH][N_MACS];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_cnt;
    logic [1:0]         r_idx;
    logic [ACC_W-1:0]   r_last_word;
    logic               r_err;
    logic [7:0]         r_drop;

    logic               w_valid;
    logic               w_full;
    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [ACC_W-1:0]   w_word;
    logic [ACC_W-1:0]   w_raw;
    logic [ACC_W-1:0]   w_out;

    assign w_valid  = (r_cnt != '0);
    assign w_full   = (r_cnt == c_FULL);
    assign w_accept = w_valid & out_if.out_ready;
    assign w_pop    = w_accept & (r_idx == 2'd3);
    // A full FIFO still takes the new frame when the head frame leaves on
    // the same edge; the write lands in the slot being vacated.
    assign w_push   = w_complete & (~w_full | w_pop);
    assign w_drop   = w_complete & w_full & ~w_pop;

    assign w_word = r_mem[r_rd_ptr][r_idx];
    // While empty the output keeps showing the last word that was accepted.
    assign w_raw  = w_valid ? w_word : r_last_word;

`ifdef RESULT_RELU_EN
    assign w_out = w_raw[ACC_W-1] ? '0 : w_raw;
`else
    assign w_out = w_raw;
`endif

    assign out_if.out_data  = w_out;
    assign out_if.out_idx   = r_idx;
    assign out_if.out_last  = (r_idx == 2'd3);
    assign out_if.out_valid = w_valid;

    assign frame_cnt     = r_cnt;
    assign overwrite_err = r_err;
    assign drop_cnt      = r_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_last_word <= '0;
            r_err       <= 1'b0;
            r_drop      <= '0;
            for (int i = 0; i < N_MACS; i++) begin
                r_lane[i] <= '0;
            end
            for (int d = 0; d < DEPTH; d++) begin
                for (int i = 0; i < N_MACS; i++) begin
                    r_mem[d][i] <= '0;
                end
            end
        end else begin
            // Capture flags clear on completion whether or not the frame fits.
            if (w_complete) begin
                r_flag <= '0;
            end else begin
                r_flag <= r_flag | valid_in;
            end
            for (int i = 0; i < N_MACS; i++) begin
                if (valid_in[i]) begin
                    r_lane[i] <= w_acc[i];
                end
            end

            if (w_push) begin
                for (int i = 0; i < N_MACS; i++) begin
                    r_mem[r_wr_ptr][i] <= w_frame[i];
                end
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end

            if (w_accept) begin
                r_idx       <= r_idx + 2'd1;
                r_last_word <= w_word;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (c_PTR_W+1)'(1);
                2'b01:   r_cnt <= r_cnt - (c_PTR_W+1)'(1);
                default: r_cnt <= r_cnt;
            endcase

            if (clr_err) begin
                r_err  <= 1'b0;
                r_drop <= '0;
            end else begin
                if (w_ovw) begin
                    r_err <= 1'b1;
                end
                if (w_drop && (r_drop != 8'hFF)) begin
                    r_drop <= r_drop + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_result_drain
// Purpose  : Self-checking bench for mac_result_drain. A reference model of
//            frames/queues tracks expected words; a monitor compares every
//            accepted output word and the status outputs each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_result_drain;

    localparam int ACC_W = 16;
    localparam int DEPTH = 4;

    typedef logic signed [ACC_W-1:0] word_t;
    typedef word_t frame_t [4];

    logic                 clk;
    logic                 rst_n;
    word_t                acc [4];
    logic [3:0]           valid_in;
    logic                 clr_err;
    logic [$clog2(DEPTH):0] frame_cnt;
    logic                 overwrite_err;
    logic [7:0]           drop_cnt;

    mac_result_drain_if #(.ACC_W(ACC_W)) oif ();

    mac_result_drain #(.ACC_W(ACC_W), .N_MACS(4), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .acc_in_0      (acc[0]),
        .acc_in_1      (acc[1]),
        .acc_in_2      (acc[2]),
        .acc_in_3      (acc[3]),
        .valid_in      (valid_in),
        .clr_err       (clr_err),
        .out_if        (oif.master),
        .frame_cnt     (frame_cnt),
        .overwrite_err (overwrite_err),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic word_t relu(input word_t w);
`ifdef RESULT_RELU_EN
        return (w < 0) ? word_t'(0) : w;
`else
        return w;
`endif
    endfunction

    // ---------------- reference model ----------------
    frame_t m_fifo [$];
    word_t  exp_data [$];
    int     exp_idx [$];
    int     m_idx;
    bit     m_flag [4];
    word_t  m_lane [4];
    bit     m_err;
    int     m_drop;
    word_t  m_last_out;

    initial begin
        frame_t f;
        int     cnt;
        bit     pop_fr, all_in, errnow;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_fifo.delete();
                exp_data.delete();
                exp_idx.delete();
                m_idx  = 0;
                m_err  = 0;
                m_drop = 0;
                for (int i = 0; i < 4; i++) begin
                    m_flag[i] = 0;
                    m_lane[i] = 0;
                end
            end else begin
                cnt    = m_fifo.size();
                pop_fr = (cnt != 0) && oif.out_ready && (m_idx == 3);
                all_in = 1;
                errnow = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!(m_flag[i] || valid_in[i])) all_in = 0;
                    if (m_flag[i] && valid_in[i]) errnow = 1;
                    f[i] = valid_in[i] ? acc[i] : m_lane[i];
                end
                if (cnt != 0 && oif.out_ready) m_idx = (m_idx + 1) % 4;
                if (pop_fr) void'(m_fifo.pop_front());
                if (all_in) begin
                    for (int i = 0; i < 4; i++) m_flag[i] = 0;
                    if (cnt < DEPTH || pop_fr) begin
                        m_fifo.push_back(f);
                        for (int i = 0; i < 4; i++) begin
                            exp_data.push_back(relu(f[i]));
                            exp_idx.push_back(i);
                        end
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (valid_in[i]) begin
                            m_lane[i] = acc[i];
                            m_flag[i] = 1;
                        end
                    end
                end
                if (clr_err) begin
                    m_err  = 0;
                    m_drop = 0;
                end else if (errnow) begin
                    m_err = 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit    prev_stall;
        word_t prev_data;
        int    prev_idx;
        word_t ed;
        int    ei;
        prev_stall = 0;
        prev_data  = 0;
        prev_idx   = 0;
        m_last_out = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
                m_last_out = 0;
            end else begin
                chk(oif.out_valid == (m_fifo.size() != 0), "out_valid", oif.out_valid, m_fifo.size() != 0);
                chk(frame_cnt == m_fifo.size(), "frame_cnt", frame_cnt, m_fifo.size());
                chk(overwrite_err == m_err, "overwrite_err", overwrite_err, m_err);
                chk(drop_cnt == m_drop, "drop_cnt", drop_cnt, m_drop);
                if (!oif.out_valid)
                    chk(oif.out_data == m_last_out, "empty_hold", oif.out_data, m_last_out);
                if (prev_stall && oif.out_valid) begin
                    chk(oif.out_data == prev_data, "stall_data", oif.out_data, prev_data);
                    chk(oif.out_idx == prev_idx, "stall_idx", oif.out_idx, prev_idx);
                end
                if (oif.out_valid && oif.out_ready) begin
                    if (exp_data.size() == 0) begin
                        chk(0, "unexpected_word", oif.out_data, 0);
                    end else begin
                        ed = exp_data.pop_front();
                        ei = exp_idx.pop_front();
                        chk(oif.out_data == ed, "out_data", oif.out_data, ed);
                        chk(oif.out_idx == ei, "out_idx", oif.out_idx, ei);
                        chk(oif.out_last == (ei == 3), "out_last", oif.out_last, ei == 3);
                        m_last_out = ed;
                    end
                end
                prev_stall = oif.out_valid && !oif.out_ready;
                prev_data  = oif.out_data;
                prev_idx   = oif.out_idx;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [3:0] v, input int d0, input int d1, input int d2,
                       input int d3, input bit rdy, input bit clr = 1'b0);
        valid_in      = v;
        acc[0]        = word_t'(d0);
        acc[1]        = word_t'(d1);
        acc[2]        = word_t'(d2);
        acc[3]        = word_t'(d3);
        oif.out_ready = rdy;
        clr_err       = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(4'b0000, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        rst_n         = 1'b0;
        valid_in      = '0;
        clr_err       = 1'b0;
        oif.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) acc[i] = '0;

        repeat (3) @(posedge clk);
        #2;
        chk(oif.out_valid == 1'b0, "rst_valid", oif.out_valid, 0);
        chk(frame_cnt == 0, "rst_frame_cnt", frame_cnt, 0);
        chk(oif.out_data == 0, "rst_data", oif.out_data, 0);
        chk(drop_cnt == 0, "rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        idle(2, 1);

        // staggered lanes
        cyc(4'b0001, 5, 0, 0, 0, 1);
        cyc(4'b0010, 0, -3, 0, 0, 1);
        cyc(4'b0100, 0, 0, 7, 0, 1);
        cyc(4'b1000, 0, 0, 0, 100, 1);
        chk(oif.out_valid == 1'b1, "latency_valid", oif.out_valid, 1);
        idle(6, 1);

        // overwrite on lane 0
        cyc(4'b0001, 10, 0, 0, 0, 1);
        cyc(4'b0001, 20, 0, 0, 0, 1);
        cyc(4'b1110, 0, 1, 2, 3, 1);
        chk(overwrite_err == 1'b1, "ovw_err", overwrite_err, 1);
        idle(6, 1);
        cyc(4'b0000, 0, 0, 0, 0, 1, 1'b1);

        // fill and drop
        for (int k = 0; k < 5; k++) cyc(4'b1111, k * 4, k * 4 + 1, k * 4 + 2, k * 4 + 3, 0);
        chk(frame_cnt == 4, "fill_cnt", frame_cnt, 4);
        chk(drop_cnt == 1, "fill_drop", drop_cnt, 1);
        idle(20, 1);

        // push at full with simultaneous pop of the head frame
        for (int k = 0; k < 4; k++) cyc(4'b1111, 50 + k, -50 - k, 60 + k, -60 - k, 0);
        idle(3, 1);
        cyc(4'b1111, 11, 22, 33, 44, 1);
        chk(frame_cnt == 4, "full_pop_cnt", frame_cnt, 4);
        chk(drop_cnt == 1, "full_pop_nodrop", drop_cnt, 1);
        idle(20, 1);

        // backpressure with negative words
        cyc(4'b1111, -8, 4, -1, 0, 0);
        for (int k = 0; k < 8; k++) idle(1, (k % 2) == 0);
        idle(4, 1);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768,
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 40) == 0);
        end
        idle(40, 1);
        chk(exp_data.size() == 0, "drain_empty", exp_data.size(), 0);

        // reset mid-stream: two frames held, head at word 2
        idle(1, 0);
        cyc(4'b1111, 1, 2, 3, 4, 0);
        cyc(4'b1111, 5, 6, 7, 8, 0);
        idle(2, 1);
        oif.out_ready = 1'b0;
        #1;
        chk(oif.out_idx == 2, "pre_rst_idx", oif.out_idx, 2);
        chk(frame_cnt == 2, "pre_rst_cnt", frame_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk(oif.out_valid == 1'b0, "async_rst_valid", oif.out_valid, 0);
        chk(frame_cnt == 0, "async_rst_cnt", frame_cnt, 0);
        chk(oif.out_idx == 0, "async_rst_idx", oif.out_idx, 0);
        chk(oif.out_data == 0, "async_rst_data", oif.out_data, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(1, 1);
        cyc(4'b1111, -2, 9, -9, 2, 1);
        idle(8, 1);
        chk(exp_data.size() == 0, "post_rst_empty", exp_data.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
- Downstream stage of the 2x2 MAC array.
- Captures the four accumulator results as each MAC raises its valid_out, and assembles them into one result frame.
- Buffers up to DEPTH complete frames in a FIFO.
- Streams frames out one word at a time on a valid/ready interface toward the writeback/output buffer.

Parameters:
- ACC_W, 16, accumulator/result word width (signed)
- N_MACS, 4, lanes per frame; fixed at 4 for the 2x2 array
- DEPTH, 4, frame FIFO depth in frames; power of two, >= 2

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- acc_in_0  in  ACC_W  signed result from MAC 0
- acc_in_1  in  ACC_W  signed result from MAC 1
- acc_in_2  in  ACC_W  signed result from MAC 2
- acc_in_3  in  ACC_W  signed result from MAC 3
- valid_in  in  N_MACS  per-lane result strobe (array valid_out)
- clr_err  in  1  synchronous clear of error flags and drop counter
- out_data  out  ACC_W  current output word
- out_idx  out  2  lane index of out_data
- out_last  out  1  high on lane 3 word of a frame
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts word when out_valid&&out_ready
- frame_cnt  out  $clog2(DEPTH)+1  frames held in FIFO
- overwrite_err  out  1  sticky: lane re-strobed before frame completed
- drop_cnt  out  8  saturating count of frames dropped on full FIFO

Behaviour:
- Reset (rst low, async): all outputs 0; capture flags cleared; FIFO empty; pointers 0; all outputs stay 0 while rst is low.
- Capture stage: per-lane register plus pending flag.
  - valid_in[i] high at a clk edge: latch acc_in_i and set flag[i].
  - Flag already set: overwrite the data and set overwrite_err.
- Frame completion:
  - Occurs in the cycle where (flags | valid_in) == 4'b1111.
  - That cycle's acc_in values are used directly; no extra cycle.
  - The frame is pushed at that edge and all flags clear at the same edge.
  - Latency: final lane strobe to out_valid is 1 cycle when the FIFO was empty.
- Full FIFO:
  - Completing frame with FIFO full and no frame fully popped that edge: frame dropped, flags still clear, drop_cnt increments and saturates at 255.
  - If the last word of the head frame is popped (out_last accepted) in the same edge, the push succeeds.
- Output:
  - out_valid = (frame_cnt != 0).
  - Words are emitted lane 0, 1, 2, 3 within a frame; out_idx gives the lane; out_last = (out_idx == 3).
  - Word index advances on out_valid&&out_ready.
  - On accepting out_last: word index wraps to 0, read pointer advances, frame_cnt decrements.
  - out_data/out_idx hold stable while out_valid && !out_ready.
- Simultaneous push and pop of a full frame: frame_cnt unchanged.
- Empty FIFO: out_ready is ignored; out_data holds its last value.
- Pointer wrap-around: modulo DEPTH.
- clr_err: zeroes overwrite_err and drop_cnt next edge. If it coincides with a new error, clr_err wins.
- Arithmetic: data is passed through bit-exact; no width change.

Optional Feature:
- Macro RESULT_RELU_EN.
  - Defined: out_data is 0 when the stored word is negative (MSB=1), else the stored word. The FIFO stores raw values; ReLU is applied combinationally at the output.
  - Undefined: raw signed value output.

Test Plan:
- Reset mid-stream: FIFO holds 2 frames, out_idx=2, rst low for 1 cycle -> all outputs 0, frame_cnt=0, out_valid=0 immediately (async).
- Staggered lanes: valid_in=0001 (acc 5), 0010 (acc -3), 0100 (acc 7), then 1000 (acc 100) on consecutive cycles, out_ready=1 -> out_valid 1 cycle after last strobe; words 5, -3, 7, 100 with idx 0..3; out_last on 100.
- Overwrite: lane0 strobed with 10 then 20 before other lanes arrive, then lanes 1-3 complete -> overwrite_err=1; frame word0=20.
- Fill and drop: out_ready=0, 5 frames completed with DEPTH=4 -> frame_cnt=4, drop_cnt=1; then out_ready=1 -> 16 words, first 4 frames in order.
- Push at full with pop: FIFO full; out_last accepted in the same cycle a new frame completes -> no drop, frame_cnt stays 4.
- Backpressure plus RELU: RESULT_RELU_EN defined, frame {-8, 4, -1, 0}, out_ready toggling 1/0 -> output 0, 4, 0, 0; data stable during stalls. Without the macro -> -8, 4, -1, 0.
